// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer
// Description : PLC program sequencer. Owns the program counter and the
//               call/return stack, fetches one ROM word per instruction and
//               resolves JMP/JMA/CLL/RET/RST locally.
//               Optional build macro: SEQ_STACK_GUARD_EN (stack over/underflow
//               traps into a sticky FAULT state instead of wrapping).
//               Opcode encoding (opcode field = rom_data[WORD_WIDTH-1:16]):
//               NOP=0x00 JMP=0x10 JMA=0x11 CLL=0x12 RET=0x13 RST=0x14
// Revision    : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
  parameter int ADDR_BITS   = 8,
  parameter int WORD_WIDTH  = 24,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [ADDR_BITS-1:0]           rom_addr,
  input  logic [WORD_WIDTH-1:0]          rom_data,
  input  logic                           stall,
  input  logic                           acu_nz,
  output logic [WORD_WIDTH-17:0]         instr_op,
  output logic [15:0]                    instr_arg,
  output logic                           instr_valid,
  output logic [$clog2(STACK_DEPTH):0]   stack_level,
  output logic                           fault
);

  localparam int OP_W  = WORD_WIDTH - 16;
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int LVL_W = SP_W + 1;

  localparam logic [OP_W-1:0]  OP_JMP   = OP_W'(8'h10);
  localparam logic [OP_W-1:0]  OP_JMA   = OP_W'(8'h11);
  localparam logic [OP_W-1:0]  OP_CLL   = OP_W'(8'h12);
  localparam logic [OP_W-1:0]  OP_RET   = OP_W'(8'h13);
  localparam logic [OP_W-1:0]  OP_RST   = OP_W'(8'h14);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [ADDR_BITS-1:0]   pc, pc_nx, pc_inc, target, top_entry;
  logic [SP_W-1:0]        sp, sp_nx;
  logic [LVL_W-1:0]       level, level_nx;
  logic [OP_W-1:0]        op_nx;
  logic [15:0]            arg_nx;
  logic                   push_en;
  logic                   ovf_trap, udf_trap;
  logic [ADDR_BITS-1:0]   stack_mem [STACK_DEPTH];

  assign pc_inc    = pc + ADDR_BITS'(1);
  assign target    = instr_arg[ADDR_BITS-1:0];
  // sp points at the next free slot, so the top of stack is one below it
  assign top_entry = stack_mem[sp - SP_W'(1)];

`ifdef SEQ_STACK_GUARD_EN
  assign ovf_trap = (level == LVL_FULL);
  assign udf_trap = (level == '0);
  assign fault    = (state == S_FAULT);
`else
  assign ovf_trap = 1'b0;
  assign udf_trap = 1'b0;
  assign fault    = 1'b0;
`endif

  assign rom_addr    = pc;
  assign instr_valid = (state == S_EXEC);
  assign stack_level = level;

  // Next-state, next-pc and stack control; everything holds unless changed
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    sp_nx    = sp;
    level_nx = level;
    op_nx    = instr_op;
    arg_nx   = instr_arg;
    push_en  = 1'b0;
    case (state)
      S_FETCH: begin
        op_nx    = rom_data[WORD_WIDTH-1:16];
        arg_nx   = rom_data[15:0];
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          state_nx = S_FETCH;
          pc_nx    = pc_inc;
          case (instr_op)
            OP_JMP: pc_nx = target;
            OP_JMA: if (acu_nz) pc_nx = target;
            OP_CLL: begin
              if (ovf_trap) begin
                state_nx = S_FAULT;
                pc_nx    = pc;
              end else begin
                push_en = 1'b1;
                sp_nx   = sp + SP_W'(1);
                pc_nx   = target;
                // overflow overwrites the oldest slot; occupancy saturates
                if (level != LVL_FULL) level_nx = level + LVL_W'(1);
              end
            end
            OP_RET: begin
              if (udf_trap) begin
                state_nx = S_FAULT;
                pc_nx    = pc;
              end else begin
                pc_nx = top_entry;
                sp_nx = sp - SP_W'(1);
                if (level != '0) level_nx = level - LVL_W'(1);
              end
            end
            OP_RST: begin
              pc_nx    = '0;
              sp_nx    = '0;
              level_nx = '0;
              op_nx    = '0;
              arg_nx   = '0;
            end
            default: ;
          endcase
        end
      end
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_FETCH;
    endcase
  end

  // State register plus pc, stack pointer, occupancy and latched instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      sp        <= '0;
      level     <= '0;
      instr_op  <= '0;
      instr_arg <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      sp        <= sp_nx;
      level     <= level_nx;
      instr_op  <= op_nx;
      instr_arg <= arg_nx;
    end
  end

  // Return-stack storage; reset forces FETCH so no push can land during rst
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[sp] <= pc_inc;
  end

endmodule
`default_nettype wire
